// File: rtl/sv_gate_sequencer.sv
// Single-qubit gate sequencer: walks amplitude pairs (i0, i1 = i0 | 1<<t) through an
// external complex-multiply unit and writes results back. SV_SEQ_PERF_EN adds stall_cycles.
module sv_gate_sequencer #(
    parameter int NUM_QUBITS      = 5,
    parameter int AMPLITUDE_WIDTH = 32,
    localparam int AW = NUM_QUBITS,
    localparam int QW = (NUM_QUBITS > 1) ? $clog2(NUM_QUBITS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [QW-1:0]              target_qubit,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic                       mem_porta_en,
    output logic                       mem_porta_we,
    output logic [AW-1:0]              mem_porta_addr,
    output logic [AMPLITUDE_WIDTH-1:0] mem_porta_din_re,
    output logic [AMPLITUDE_WIDTH-1:0] mem_porta_din_im,
    input  logic [AMPLITUDE_WIDTH-1:0] mem_porta_dout_re,
    input  logic [AMPLITUDE_WIDTH-1:0] mem_porta_dout_im,
    output logic                       mem_portb_en,
    output logic [AW-1:0]              mem_portb_addr,
    input  logic [AMPLITUDE_WIDTH-1:0] mem_portb_dout_re,
    input  logic [AMPLITUDE_WIDTH-1:0] mem_portb_dout_im,
    output logic                       pair_valid,
    input  logic                       pair_ready,
    output logic [AMPLITUDE_WIDTH-1:0] pair_a0_re,
    output logic [AMPLITUDE_WIDTH-1:0] pair_a0_im,
    output logic [AMPLITUDE_WIDTH-1:0] pair_a1_re,
    output logic [AMPLITUDE_WIDTH-1:0] pair_a1_im,
    input  logic                       res_valid,
    input  logic [AMPLITUDE_WIDTH-1:0] res_a0_re,
    input  logic [AMPLITUDE_WIDTH-1:0] res_a0_im,
    input  logic [AMPLITUDE_WIDTH-1:0] res_a1_re,
    input  logic [AMPLITUDE_WIDTH-1:0] res_a1_im
`ifdef SV_SEQ_PERF_EN
    ,
    output logic [31:0]                stall_cycles
`endif
);
    localparam int KW = (AW > 1) ? AW - 1 : 1;
    localparam int DW = AMPLITUDE_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_LATCH, S_ISSUE, S_RESULT, S_WR0, S_WR1, S_DONE
    } state_t;

    state_t        state, state_nx;
    logic [QW-1:0] tq;
    logic [KW-1:0] k;
    logic [AW-1:0] kx, mask, i0, i1;
    logic [DW-1:0] r0_re, r0_im, r1_re, r1_im;
    logic          tgt_ok, accept, last;

    assign tgt_ok = int'(target_qubit) < NUM_QUBITS;
    assign accept = (state == S_IDLE) && start && tgt_ok;
    assign last   = (k == {KW{1'b1}});

    // i0 is k with a zero spliced in at bit t
    always_comb begin
        kx   = AW'(k);
        mask = (AW'(1) << tq) - AW'(1);
        i0   = (kx & mask) | ((kx & ~mask) << 1);
        i1   = i0 | (AW'(1) << tq);
    end

    always_comb begin
        state_nx         = state;
        busy             = (state != S_IDLE);
        pair_valid       = 1'b0;
        mem_porta_en     = 1'b0;
        mem_porta_we     = 1'b0;
        mem_porta_addr   = '0;
        mem_porta_din_re = '0;
        mem_porta_din_im = '0;
        mem_portb_en     = 1'b0;
        mem_portb_addr   = '0;
        case (state)
            S_IDLE:   if (accept) state_nx = S_READ;
            S_READ: begin
                mem_porta_en   = 1'b1;
                mem_porta_addr = i0;
                mem_portb_en   = 1'b1;
                mem_portb_addr = i1;
                state_nx       = S_LATCH;
            end
            S_LATCH:  state_nx = S_ISSUE;
            S_ISSUE: begin
                pair_valid = 1'b1;
                if (pair_ready) state_nx = S_RESULT;
            end
            S_RESULT: if (res_valid) state_nx = S_WR0;
            S_WR0: begin
                mem_porta_en     = 1'b1;
                mem_porta_we     = 1'b1;
                mem_porta_addr   = i0;
                mem_porta_din_re = r0_re;
                mem_porta_din_im = r0_im;
                state_nx         = S_WR1;
            end
            S_WR1: begin
                mem_porta_en     = 1'b1;
                mem_porta_we     = 1'b1;
                mem_porta_addr   = i1;
                mem_porta_din_re = r1_re;
                mem_porta_din_im = r1_im;
                state_nx         = last ? S_DONE : S_READ;
            end
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            done       <= 1'b0;
            err        <= 1'b0;
            tq         <= '0;
            k          <= '0;
            pair_a0_re <= '0;
            pair_a0_im <= '0;
            pair_a1_re <= '0;
            pair_a1_im <= '0;
            r0_re      <= '0;
            r0_im      <= '0;
            r1_re      <= '0;
            r1_im      <= '0;
        end else begin
            state <= state_nx;
            done  <= (state == S_DONE);
            err   <= (state == S_IDLE) && start && !tgt_ok;
            if (accept) begin
                tq <= target_qubit;
                k  <= '0;
            end
            if (state == S_WR1 && !last) k <= k + 1'b1;
            if (state == S_LATCH) begin
                pair_a0_re <= mem_porta_dout_re;
                pair_a0_im <= mem_porta_dout_im;
                pair_a1_re <= mem_portb_dout_re;
                pair_a1_im <= mem_portb_dout_im;
            end
            if (state == S_RESULT && res_valid) begin
                r0_re <= res_a0_re;
                r0_im <= res_a0_im;
                r1_re <= res_a1_re;
                r1_im <= res_a1_im;
            end
        end
    end

`ifdef SV_SEQ_PERF_EN
    // Saturating count of cycles lost waiting on the compute unit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (accept) begin
            stall_cycles <= '0;
        end else if (((state == S_ISSUE) && !pair_ready) ||
                     ((state == S_RESULT) && !res_valid)) begin
            if (stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
